multi_clk_div: RTL and testbench

//  N-channel programmable clock-enable and divided-clock generator. It runs off one

---
 rtl/multi_clk_div.sv | 184 ++++++++++++++++++
 tb/tb_multi_clk_div.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clk_div.sv
// -----------------------------------------------------------------------------
// multi_clk_div
// N-channel programmable clock-enable / divided-clock generator running off a
// single system clock. Each channel produces a 50%-duty divided clock whose
// high and low phases are each (r+1) system-clock cycles long, plus one-cycle
// rise/fall ticks. Ratios are staged in pending registers and applied only at
// period boundaries (high->low toggle), while parked, or on a sync strobe, so
// a divided clock never shows a runt pulse because of a ratio change.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   en         in   [NUM_CH]        per-channel enable
//   half_per   in   [NUM_CH*CNT_W]  per-channel half-period r, ch i at [i*CNT_W +: CNT_W]
//   load       in   strobe: capture half_per of all channels into pending regs
//   sync       in   strobe: restart all enabled channels phase-aligned (low, cnt=0)
//   div_clk    out  [NUM_CH]  divided clocks
//   rise_tick  out  [NUM_CH]  pulse in the first high cycle of div_clk[i]
//   fall_tick  out  [NUM_CH]  pulse in the first low cycle after a completed high phase
//   pend       out  [NUM_CH]  captured ratio not yet applied to channel i
// -----------------------------------------------------------------------------
module multi_clk_div #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RESET_HALF = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH*CNT_W-1:0]   half_per,
    input  logic                      load,
    input  logic                      sync,
    output logic [NUM_CH-1:0]         div_clk,
    output logic [NUM_CH-1:0]         rise_tick,
    output logic [NUM_CH-1:0]         fall_tick,
    output logic [NUM_CH-1:0]         pend
);

    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_RUN_LO = 2'd1,
        ST_RUN_HI = 2'd2,
        ST_DRAIN  = 2'd3
    } ch_state_e;

    localparam logic [CNT_W-1:0] RST_HALF_C = CNT_W'(RESET_HALF);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_e          st_q, st_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [CNT_W-1:0]   active_q, active_d;
        logic [CNT_W-1:0]   pending_q, pending_d;
        logic               div_q, div_d;
        logic               rise_q, rise_d;
        logic               fall_q, fall_d;
        logic               pend_q, pend_d;
        logic [CNT_W-1:0]   hp_s;
        logic               at_end_s;
        logic               sync_ch_s;
        logic               apply_s;

        assign hp_s      = half_per[g*CNT_W +: CNT_W];
        // >= rather than == so a corrupted counter still terminates its phase
        assign at_end_s  = (cnt_q >= active_q);
        assign sync_ch_s = sync & en[g];

        // Next-state, counter, phase level, tick and ratio-staging logic for one channel
        always_comb begin
            st_d      = st_q;
            cnt_d     = cnt_q;
            div_d     = div_q;
            rise_d    = 1'b0;
            fall_d    = 1'b0;
            apply_s   = 1'b0;
            active_d  = active_q;
            pending_d = pending_q;
            pend_d    = pend_q;

            if (sync_ch_s) begin
                // Deliberate truncation: restart low with no fall tick
                st_d    = ST_RUN_LO;
                cnt_d   = CNT_ZERO;
                div_d   = 1'b0;
                apply_s = 1'b1;
            end else begin
                case (st_q)
                    ST_PARK: begin
                        cnt_d   = CNT_ZERO;
                        div_d   = 1'b0;
                        apply_s = pend_q;
                        if (en[g]) begin
                            st_d = ST_RUN_LO;
                        end else begin
                            st_d = ST_PARK;
                        end
                    end
                    ST_RUN_LO: begin
                        if (!en[g]) begin
                            st_d  = ST_PARK;
                            cnt_d = CNT_ZERO;
                            div_d = 1'b0;
                        end else if (at_end_s) begin
                            st_d   = ST_RUN_HI;
                            cnt_d  = CNT_ZERO;
                            div_d  = 1'b1;
                            rise_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    // DRAIN is a high phase that parks at its end unless en returns
                    ST_RUN_HI, ST_DRAIN: begin
                        if (at_end_s) begin
                            st_d    = en[g] ? ST_RUN_LO : ST_PARK;
                            cnt_d   = CNT_ZERO;
                            div_d   = 1'b0;
                            fall_d  = 1'b1;
                            apply_s = pend_q;
                        end else begin
                            st_d  = en[g] ? ST_RUN_HI : ST_DRAIN;
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        st_d  = ST_PARK;
                        cnt_d = CNT_ZERO;
                        div_d = 1'b0;
                    end
                endcase
            end

            // Apply uses the old pending value; a coincident load then restages
            if (apply_s) begin
                active_d = pending_q;
                pend_d   = 1'b0;
            end else begin
                active_d = active_q;
            end

            if (load) begin
                pending_d = hp_s;
                if (sync_ch_s) begin
                    active_d = hp_s;
                    pend_d   = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end else begin
                pending_d = pending_q;
            end
        end

        // Channel state registers with asynchronous active-low reset
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st_q      <= ST_PARK;
                cnt_q     <= CNT_ZERO;
                active_q  <= RST_HALF_C;
                pending_q <= RST_HALF_C;
                div_q     <= 1'b0;
                rise_q    <= 1'b0;
                fall_q    <= 1'b0;
                pend_q    <= 1'b0;
            end else begin
                st_q      <= st_d;
                cnt_q     <= cnt_d;
                active_q  <= active_d;
                pending_q <= pending_d;
                div_q     <= div_d;
                rise_q    <= rise_d;
                fall_q    <= fall_d;
                pend_q    <= pend_d;
            end
        end

        assign div_clk[g]   = div_q;
        assign rise_tick[g] = rise_q;
        assign fall_tick[g] = fall_q;
        assign pend[g]      = pend_q;
    end

endmodule

// File: tb/tb_multi_clk_div.sv
module tb_multi_clk_div;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] half_per;
    logic                    load;
    logic                    sync;
    logic [NUM_CH-1:0]       div_clk;
    logic [NUM_CH-1:0]       rise_tick;
    logic [NUM_CH-1:0]       fall_tick;
    logic [NUM_CH-1:0]       pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_clk_div #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_HALF(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .half_per  (half_per),
        .load      (load),
        .sync      (sync),
        .div_clk   (div_clk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .pend      (pend)
    );

    // Reference model: each channel is parked or running; a running channel
    // sits at a level and counts down the edges remaining before it toggles.
    bit m_run [NUM_CH];
    bit m_lvl [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_rise[NUM_CH];
    bit m_fall[NUM_CH];
    int m_rem [NUM_CH];
    int m_act [NUM_CH];
    int m_pval[NUM_CH];

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_run[i] = 0; m_lvl[i] = 0; m_pend[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
            m_rem[i] = 0; m_act[i] = 0; m_pval[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            int r;
            r = int'(half_per[i*CNT_W +: CNT_W]);
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (sync && en[i]) begin
                if (load) m_pval[i] = r;
                m_act[i]  = m_pval[i];
                m_pend[i] = 0;
                m_run[i]  = 1;
                m_lvl[i]  = 0;
                m_rem[i]  = m_act[i] + 1;
            end else begin
                if (!m_run[i]) begin
                    if (m_pend[i]) begin m_act[i] = m_pval[i]; m_pend[i] = 0; end
                    if (en[i]) begin m_run[i] = 1; m_lvl[i] = 0; m_rem[i] = m_act[i] + 1; end
                end else if (!m_lvl[i]) begin
                    if (!en[i]) m_run[i] = 0;
                    else begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin m_lvl[i] = 1; m_rise[i] = 1; m_rem[i] = m_act[i] + 1; end
                    end
                end else begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_lvl[i]  = 0;
                        m_fall[i] = 1;
                        if (m_pend[i]) begin m_act[i] = m_pval[i]; m_pend[i] = 0; end
                        if (en[i]) m_rem[i] = m_act[i] + 1;
                        else       m_run[i] = 0;
                    end
                end
                if (load) begin m_pval[i] = r; m_pend[i] = 1; end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [NUM_CH-1:0] ed, er, ef, ep;
        for (int i = 0; i < NUM_CH; i++) begin
            ed[i] = m_lvl[i]; er[i] = m_rise[i]; ef[i] = m_fall[i]; ep[i] = m_pend[i];
        end
        checks++;
        if ({div_clk, rise_tick, fall_tick, pend} !== {ed, er, ef, ep}) begin
            errors++;
            $display("FAIL %s: div/rise/fall/pend got %b/%b/%b/%b expected %b/%b/%b/%b",
                     tag, div_clk, rise_tick, fall_tick, pend, ed, er, ef, ep);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge: model follows the same inputs, outputs sampled 1ns after the edge
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
        load = 1'b0;
        sync = 1'b0;
    endtask

    task automatic wait_rise(input int ch, input int bound, input string tag, output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < bound) begin
            step(tag);
            n++;
            if (rise_tick[ch]) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no rise_tick[%0d] within %0d cycles", tag, ch, bound);
        end
    endtask

    // Counts further high cycles until div_clk[ch] reads 0
    task automatic high_rest(input int ch, input int bound, input string tag, output int n);
        bit done;
        done = 0;
        n = 0;
        while (!done && n < bound) begin
            step(tag);
            if (div_clk[ch]) n++;
            else done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: div_clk[%0d] stayed high beyond %0d cycles", tag, ch, bound);
        end
    endtask

    typedef struct {
        logic [2:0]  en;
        logic [23:0] hp;
        logic        ld;
        logic        sy;
        logic [2:0]  ediv;
        logic [2:0]  erise;
        logic [2:0]  efall;
        logic [2:0]  epend;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        localparam logic [23:0] HP_A = 24'h030100;

        tbl[0]  = '{3'b111, HP_A, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{3'b111, HP_A, 1'b0, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000};
        tbl[2]  = '{3'b111, HP_A, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000};
        tbl[3]  = '{3'b111, HP_A, 1'b0, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000};
        tbl[4]  = '{3'b111, HP_A, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b111};
        tbl[5]  = '{3'b111, HP_A, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[6]  = '{3'b111, HP_A, 1'b0, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000};
        tbl[7]  = '{3'b111, HP_A, 1'b0, 1'b0, 3'b010, 3'b010, 3'b001, 3'b000};
        tbl[8]  = '{3'b111, HP_A, 1'b0, 1'b0, 3'b011, 3'b001, 3'b000, 3'b000};
        tbl[9]  = '{3'b111, HP_A, 1'b0, 1'b0, 3'b100, 3'b100, 3'b011, 3'b000};
        tbl[10] = '{3'b111, HP_A, 1'b0, 1'b0, 3'b101, 3'b001, 3'b000, 3'b000};
        tbl[11] = '{3'b111, HP_A, 1'b0, 1'b0, 3'b110, 3'b010, 3'b001, 3'b000};

        rst = 1'b0; en = 3'b111; half_per = HP_A; load = 1'b0; sync = 1'b0;
        model_reset();
        #12;
        check_val("reset_outputs", int'({div_clk, rise_tick, fall_tick, pend}), 0);
        rst = 1'b1;

        // Reset ratio run, then load + sync to {3,1,0}
        for (int v = 0; v < 12; v++) begin
            en = tbl[v].en; half_per = tbl[v].hp; load = tbl[v].ld; sync = tbl[v].sy;
            step($sformatf("tbl%0d_model", v));
            checks++;
            if ({div_clk, rise_tick, fall_tick, pend} !== {tbl[v].ediv, tbl[v].erise, tbl[v].efall, tbl[v].epend}) begin
                errors++;
                $display("FAIL tbl%0d: div/rise/fall/pend got %b/%b/%b/%b expected %b/%b/%b/%b", v,
                         div_clk, rise_tick, fall_tick, pend,
                         tbl[v].ediv, tbl[v].erise, tbl[v].efall, tbl[v].epend);
            end
        end

        // Ratio change on ch2 during a high phase
        wait_rise(2, 20, "t3_rise", n);
        half_per = 24'h000100; load = 1'b1;
        step("t3_load");
        check_val("t3_pend_set", int'(pend[2]), 1);
        check_val("t3_still_high", int'(div_clk[2]), 1);
        high_rest(2, 20, "t3_old_high", n);
        check_val("t3_old_high_len", n + 2, 4);
        check_val("t3_fall_tick", int'(fall_tick[2]), 1);
        check_val("t3_pend_clr", int'(pend[2]), 0);
        wait_rise(2, 20, "t3_rise2", n);
        high_rest(2, 20, "t3_new_high", n);
        check_val("t3_new_high_len", n + 1, 1);

        // Simultaneous load+sync, then enable drop in high and low phases of ch1
        half_per = 24'h000300; load = 1'b1; sync = 1'b1;
        step("t4_ldsync");
        check_val("t4_pend_ldsync", int'(pend), 0);
        wait_rise(1, 20, "t4_rise", n);
        en = 3'b101;
        high_rest(1, 20, "t4_drain", n);
        check_val("t4_drain_high_len", n + 1, 4);
        check_val("t4_drain_fall", int'(fall_tick[1]), 1);
        step("t4_park1");
        step("t4_park2");
        check_val("t4_parked", int'({div_clk[1], rise_tick[1], fall_tick[1]}), 0);
        en = 3'b111;
        wait_rise(1, 20, "t4_rerise", n);
        high_rest(1, 20, "t4_rehigh", n);
        en = 3'b101;
        step("t4_lo_drop");
        check_val("t4_lo_drop_quiet", int'({div_clk[1], rise_tick[1], fall_tick[1]}), 0);
        for (int k = 0; k < 6; k++) step("t4_lo_park");
        check_val("t4_lo_parked", int'(div_clk[1]), 0);

        // Sync during ch2 high phase truncates without a fall tick
        en = 3'b111; half_per = 24'h030100; load = 1'b1; sync = 1'b1;
        step("t5_setup");
        wait_rise(2, 20, "t5_rise", n);
        step("t5_hi");
        sync = 1'b1;
        step("t5_sync");
        check_val("t5_trunc_low", int'({div_clk[2], fall_tick[2]}), 0);
        wait_rise(2, 20, "t5_rise_after", n);
        check_val("t5_rise_delay", n, 4);

        // Largest ratio on ch0: 256-cycle phases
        half_per = 24'h0301FF; load = 1'b1; sync = 1'b1;
        step("max_setup");
        wait_rise(0, 600, "max_rise", n);
        check_val("max_low_len", n, 256);
        high_rest(0, 600, "max_high", n);
        check_val("max_high_len", n + 1, 256);

        // Asynchronous reset between edges while ch2 is high
        half_per = 24'h030100; load = 1'b1; sync = 1'b1;
        step("t6_setup");
        wait_rise(2, 20, "t6_rise", n);
        step("t6_hi");
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_async_zero", int'({div_clk, rise_tick, fall_tick, pend}), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step("t6_rel1");
        step("t6_rel2");
        check_val("t6_ratio_reset_hi", int'(div_clk), 7);
        step("t6_rel3");
        check_val("t6_ratio_reset_lo", int'(div_clk), 0);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                en[i] = ($urandom_range(0, 7) != 0);
                half_per[i*CNT_W +: CNT_W] = 8'($urandom_range(0, 4));
            end
            load = ($urandom_range(0, 9) == 0);
            sync = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
